// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
//
// Issue control between the decode (D) stage and the multiply/divide unit.
// Opcodes in D are forwarded into an E-stage register that drives the MDU.
// A shadow latency counter tracks how long a started mult/div keeps the MDU
// occupied. Any further MDU operation in D is frozen while the MDU is busy,
// or while a start op sits in E and is about to make it busy.
//
// Opcode map: nop=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6,
//             mthi=7, mtlo=8. Encodings 9-15 behave exactly like nop.
// Latency:    mult/multu = 5 cycles, div/divu = 10 cycles.
//
// Optional feature macro:
//   MDU_ISSUE_PERF_EN  - when defined, stall_cnt counts D-stage stall cycles
//                        and saturates at 0xFFFF_FFFF. When undefined,
//                        stall_cnt is tied to zero and no counter is built.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   id_valid   in   1  D stage holds a valid instruction
//   id_op      in   4  D-stage MDU opcode
//   id_rs      in  32  forwarded D-stage operand 1
//   id_rt      in  32  forwarded D-stage operand 2
//   exc_req    in   1  exception/interrupt flush request
//   id_stall   out  1  freezes the D stage (combinational)
//   mdu_op     out  4  registered E-stage opcode to the MDU
//   mdu_data1  out 32  registered E-stage operand 1
//   mdu_data2  out 32  registered E-stage operand 2
//   mdu_busy   out  1  shadow latency counter is running
//   stall_cnt  out 32  stall-cycle statistic (zero unless MDU_ISSUE_PERF_EN)
// ---------------------------------------------------------------------------
module mdu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [3:0]  id_op,
    input  logic [31:0] id_rs,
    input  logic [31:0] id_rt,
    input  logic        exc_req,
    output logic        id_stall,
    output logic [3:0]  mdu_op,
    output logic [31:0] mdu_data1,
    output logic [31:0] mdu_data2,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt
);

    // Opcode encodings
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Latencies; the counter is 4 bits wide so the largest value must fit.
    localparam logic [3:0] LAT_MUL  = 4'd5;
    localparam logic [3:0] LAT_DIV  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Opcode helpers
    // -----------------------------------------------------------------------

    // Fold the unused encodings 9-15 onto nop so nothing downstream sees them.
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        logic [3:0] res;
        if (op > OP_MTLO) begin
            res = OP_NOP;
        end else begin
            res = op;
        end
        return res;
    endfunction

    // mult/multu/div/divu occupy the MDU for several cycles.
    function automatic logic is_start_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    // Shadow-counter load value for a start op; zero for everything else.
    function automatic logic [3:0] op_latency(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            OP_MULT, OP_MULTU: res = LAT_MUL;
            OP_DIV,  OP_DIVU:  res = LAT_DIV;
            default:           res = 4'd0;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [3:0]  mdu_op_r;
    logic [31:0] mdu_data1_r;
    logic [31:0] mdu_data2_r;

    logic [3:0]  id_op_norm_s;
    logic        id_mdu_op_s;
    logic        e_start_s;
    logic        id_stall_s;

    // Decode the D-stage request and derive the stall.
    // A start op in E stalls D for one cycle before BUSY is even entered, so
    // an op behind it waits 1 + LAT cycles in total.
    always_comb begin
        id_op_norm_s = norm_op(id_op);
        id_mdu_op_s  = 1'b0;
        e_start_s    = is_start_op(mdu_op_r);
        id_stall_s   = 1'b0;
        if (id_valid && (id_op_norm_s != OP_NOP)) begin
            id_mdu_op_s = 1'b1;
        end else begin
            id_mdu_op_s = 1'b0;
        end
        if (id_mdu_op_s && ((state_r == ST_BUSY) || e_start_s)) begin
            id_stall_s = 1'b1;
        end else begin
            id_stall_s = 1'b0;
        end
    end

    // E-stage register: a stall or flush injects a bubble but leaves the
    // operand registers untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_op_r    <= OP_NOP;
            mdu_data1_r <= 32'd0;
            mdu_data2_r <= 32'd0;
        end else if (id_stall_s || exc_req) begin
            mdu_op_r    <= OP_NOP;
        end else begin
            mdu_op_r    <= id_valid ? id_op_norm_s : OP_NOP;
            mdu_data1_r <= id_rs;
            mdu_data2_r <= id_rt;
        end
    end

    // Shadow latency FSM. A start op in E launches BUSY unless flushed; once
    // running, BUSY always completes (only reset abandons it).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (e_start_s && !exc_req) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= op_latency(mdu_op_r);
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= cnt_r;
                    end
                end
                ST_BUSY: begin
                    // Counter runs LAT..1; the cycle showing 1 is the last
                    // BUSY cycle. A zero count cannot occur in BUSY but would
                    // also drop back to IDLE rather than wrap.
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end else begin
                        state_r <= ST_BUSY;
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

`ifdef MDU_ISSUE_PERF_EN
    logic [31:0] stall_cnt_r;

    // Count D-stage stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (id_stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign id_stall  = id_stall_s;
    assign mdu_op    = mdu_op_r;
    assign mdu_data1 = mdu_data1_r;
    assign mdu_data2 = mdu_data2_r;
    assign mdu_busy  = (state_r == ST_BUSY);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl
//
// Self-checking bench for mdu_issue_ctrl. A driver task presents one
// instruction in D and holds it until the stage accepts it; every accepted
// MDU op is pushed to a scoreboard with the cycle it must appear in E. A
// negedge monitor pops and compares whenever mdu_op is non-zero, and tallies
// busy/stall cycles for the directed scenario checks.
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [31:0] id_rs;
    logic [31:0] id_rt;
    logic        exc_req;
    logic        id_stall;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_data1;
    logic [31:0] mdu_data2;
    logic        mdu_busy;
    logic [31:0] stall_cnt;

    mdu_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .exc_req   (exc_req),
        .id_stall  (id_stall),
        .mdu_op    (mdu_op),
        .mdu_data1 (mdu_data1),
        .mdu_data2 (mdu_data2),
        .mdu_busy  (mdu_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

`ifdef MDU_ISSUE_PERF_EN
    localparam logic [31:0] EXP_STALL_CNT_A = 32'd6;
`else
    localparam logic [31:0] EXP_STALL_CNT_A = 32'd0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   busy_seen = 0;
    int   stall_seen = 0;
    int   st;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_norm(input logic [3:0] op);
        return (op > 4'd8) ? 4'd0 : op;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor and busy/stall tallies.
    always @(negedge clk) begin
        if (!reset) begin
            if (mdu_busy) busy_seen++;
            if (id_stall) stall_seen++;
            if (mdu_op != 4'd0) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_mdu_op", {28'd0, mdu_op}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("mdu_op", {28'd0, mdu_op}, {28'd0, mon_e.op});
                    check_eq("mdu_data1", mdu_data1, mon_e.d1);
                    check_eq("mdu_data2", mdu_data2, mon_e.d2);
                    check_eq("issue_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one instruction in D until accepted; report stalled cycles.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        id_valid = 1'b1;
        id_op    = op;
        id_rs    = rs;
        id_rt    = rt;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!id_stall && !exc_req) begin
                done = 1'b1;
                if (exp_norm(op) != 4'd0) sb.push_back('{exp_norm(op), rs, rt, cyc + 1});
            end else begin
                stalls++;
            end
            tick();
        end
        check_eq("issue_accepted", {31'd0, done}, 32'd1);
        id_valid = 1'b0;
        id_op    = 4'd0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin
            if (!mdu_busy) idle = 1'b1;
            else tick();
        end
        check_eq("idle_reached", {31'd0, idle}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        id_valid = 1'b1;
        id_op    = 4'd1;
        id_rs    = 32'h1234_5678;
        id_rt    = 32'h9ABC_DEF0;
        exc_req  = 1'b0;
        repeat (3) tick();

        // Reset state, with a mult held in D to show reset overrides it.
        check_eq("rst_mdu_op", {28'd0, mdu_op}, 32'd0);
        check_eq("rst_data1", mdu_data1, 32'd0);
        check_eq("rst_data2", mdu_data2, 32'd0);
        check_eq("rst_busy", {31'd0, mdu_busy}, 32'd0);
        check_eq("rst_stall", {31'd0, id_stall}, 32'd0);
        check_eq("rst_stall_cnt", stall_cnt, 32'd0);
        id_valid = 1'b0;
        id_op    = 4'd0;
        reset    = 1'b0;
        tick();

        // mult then mflo: 1 + 5 stall cycles, 5 busy cycles.
        busy_seen = 0;
        issue(4'd1, 32'd3, 32'd5, st);
        check_eq("a_mult_stall", st, 32'd0);
        issue(4'd6, 32'h0000_000A, 32'h0000_000B, st);
        check_eq("a_mflo_stall", st, 32'd6);
        check_eq("a_stall_cnt", stall_cnt, EXP_STALL_CNT_A);
        wait_idle();
        check_eq("a_busy_cycles", busy_seen, 32'd5);

        // divu then mfhi: 1 + 10 stall cycles, 10 busy cycles.
        busy_seen = 0;
        issue(4'd4, 32'd100, 32'd7, st);
        issue(4'd5, 32'd0, 32'd0, st);
        check_eq("b_mfhi_stall", st, 32'd11);
        wait_idle();
        check_eq("b_busy_cycles", busy_seen, 32'd10);

        // Flush of a mult sitting in E: no BUSY, next op not stalled.
        busy_seen = 0;
        issue(4'd1, 32'd7, 32'd9, st);
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        check_eq("c_flush_op", {28'd0, mdu_op}, 32'd0);
        check_eq("c_flush_busy", {31'd0, mdu_busy}, 32'd0);
        issue(4'd6, 32'h55, 32'hAA, st);
        check_eq("c_next_stall", st, 32'd0);
        wait_idle();
        check_eq("c_busy_cycles", busy_seen, 32'd0);

        // div with exc_req pulsed at count 4: BUSY still runs 10 cycles.
        busy_seen = 0;
        issue(4'd3, 32'hFFFF_FFFF, 32'h8000_0000, st);
        repeat (7) tick();
        check_eq("d_busy_mid", {31'd0, mdu_busy}, 32'd1);
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        wait_idle();
        check_eq("d_busy_cycles", busy_seen, 32'd10);

        // Reset during BUSY abandons the op.
        issue(4'd2, 32'd11, 32'd13, st);
        tick();
        tick();
        check_eq("d_busy_before_rst", {31'd0, mdu_busy}, 32'd1);
        reset    = 1'b1;
        id_valid = 1'b1;
        id_op    = 4'd1;
        tick();
        check_eq("d_rst_busy", {31'd0, mdu_busy}, 32'd0);
        check_eq("d_rst_mdu_op", {28'd0, mdu_op}, 32'd0);
        id_valid = 1'b0;
        id_op    = 4'd0;
        reset    = 1'b0;
        tick();
        check_eq("d_after_rst_busy", {31'd0, mdu_busy}, 32'd0);

        // mthi then mfhi back to back: no stall, no BUSY.
        busy_seen  = 0;
        stall_seen = 0;
        issue(4'd7, 32'hDEAD_BEEF, 32'd0, st);
        check_eq("e_mthi_stall", st, 32'd0);
        issue(4'd5, 32'd0, 32'd0, st);
        check_eq("e_mfhi_stall", st, 32'd0);
        wait_idle();
        check_eq("e_stall_seen", stall_seen, 32'd0);
        check_eq("e_busy_seen", busy_seen, 32'd0);

        // Encodings 9-15 are nops: never stalled, never reach E.
        issue(4'd1, 32'd1, 32'd2, st);
        issue(4'd12, 32'd3, 32'd4, st);
        check_eq("f_inv_stall", st, 32'd0);
        check_eq("f_inv_mdu_op", {28'd0, mdu_op}, 32'd0);
        issue(4'd2, 32'd21, 32'd22, st);
        check_eq("f_multu_stall", st, 32'd5);
        wait_idle();

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
